// File: rtl/rob_retire_ctrl.sv
// Retirement and pointer controller for a 3-bank interleaved reorder buffer.
// Retires up to three heads in program order and sequences the flush after a mispredict.
module rob_retire_ctrl (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [2:0]                                   bank_head_complete,
  input  logic [2:0]                                   bank_head_misp,
  input  logic                                         retire_stall,
  input  logic [1:0]                                   dispatch_num,
  input  logic                                         flush_ack,
  output logic [2:0]                                   bank_head_accept,
  output logic [2:0][4:0]                              bank_head_ptr,
  output logic [2:0][4:0]                              bank_tail_ptr,
  output logic [1:0]                                   retire_count,
  output logic [6:0]                                   free_slots,
  output logic                                         flush,
  output logic                                         dispatch_ready
);

  localparam int unsigned MACHINE_WIDTH  = 3;
  localparam int unsigned ROB_DEPTH_BANK = 32;
  localparam int unsigned ROB_WIDTH_BANK = $clog2(ROB_DEPTH_BANK);
  localparam int unsigned ROB_DEPTH      = MACHINE_WIDTH * ROB_DEPTH_BANK;
  localparam int unsigned OCC_W          = 7;

  typedef logic [1:0]                bank_t;
  typedef logic [ROB_WIDTH_BANK-1:0] row_t;

  typedef struct packed {
    row_t  row;
    bank_t bank;
  } ptr_t;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t           state;
  ptr_t             head;
  ptr_t             tail;
  logic [OCC_W-1:0] occ;

  ptr_t             head_n;
  ptr_t             tail_n;
  logic [OCC_W-1:0] occ_n;
  bank_t            s0;
  bank_t            s1;
  bank_t            s2;
  logic             r0;
  logic             r1;
  logic             r2;
  logic             misp_retire;
  logic             disp_ok;
  logic [1:0]       disp_acc;

  // (b + n) mod 3 for b in 0..2, n in 0..3
  function automatic bank_t bank_add(input bank_t b, input logic [1:0] n);
    logic [2:0] sum;
    sum = 3'(b) + 3'(n);
    if (sum >= 3'd3) begin
      bank_add = 2'(sum - 3'd3);
    end else begin
      bank_add = 2'(sum);
    end
  endfunction

  // Advance a global pointer by n entries; bank wrap carries into the row.
  function automatic ptr_t ptr_adv(input ptr_t p, input logic [1:0] n);
    logic [2:0] sum;
    sum     = 3'(p.bank) + 3'(n);
    ptr_adv = p;
    if (sum >= 3'd3) begin
      ptr_adv.bank = 2'(sum - 3'd3);
      ptr_adv.row  = p.row + row_t'(1);
    end else begin
      ptr_adv.bank = 2'(sum);
    end
  endfunction

  // Banks below the global bank index are already one row ahead.
  function automatic logic [2:0][4:0] bank_ptrs(input ptr_t p);
    for (int b = 0; b < 3; b++) begin
      bank_ptrs[b] = p.row + ((2'(b) < p.bank) ? row_t'(1) : row_t'(0));
    end
  endfunction

  // In-order retire slot selection; a mispredicted head blocks younger slots.
  always_comb begin
    bank_head_accept = 3'b000;
    retire_count     = 2'd0;
    s0 = head.bank;
    s1 = bank_add(head.bank, 2'd1);
    s2 = bank_add(head.bank, 2'd2);
    r0 = (state == S_RUN) && !retire_stall && (occ > 7'd0) && bank_head_complete[s0];
    r1 = r0 && !bank_head_misp[s0] && (occ > 7'd1) && bank_head_complete[s1];
    r2 = r1 && !bank_head_misp[s1] && (occ > 7'd2) && bank_head_complete[s2];
    misp_retire = (r0 && bank_head_misp[s0]) || (r1 && bank_head_misp[s1]) ||
                  (r2 && bank_head_misp[s2]);
    if (r0) bank_head_accept[s0] = 1'b1;
    if (r1) bank_head_accept[s1] = 1'b1;
    if (r2) bank_head_accept[s2] = 1'b1;
    retire_count = 2'(r0) + 2'(r1) + 2'(r2);
  end

  // Next pointer and occupancy values
  always_comb begin
    head_n   = head;
    tail_n   = tail;
    occ_n    = occ;
    disp_ok  = (state == S_RUN) && (dispatch_num != 2'd0) &&
               (OCC_W'(dispatch_num) <= (OCC_W'(ROB_DEPTH) - occ));
    disp_acc = disp_ok ? dispatch_num : 2'd0;
    case (state)
      S_RUN: begin
        head_n = ptr_adv(head, retire_count);
        tail_n = ptr_adv(tail, disp_acc);
        occ_n  = occ + OCC_W'(disp_acc) - OCC_W'(retire_count);
      end
      S_FLUSH: begin
        tail_n = head;
        occ_n  = '0;
      end
      default: ;
    endcase
  end

  // State, pointer registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_RUN;
      head           <= '0;
      tail           <= '0;
      occ            <= '0;
      flush          <= 1'b0;
      dispatch_ready <= 1'b1;
      free_slots     <= OCC_W'(ROB_DEPTH);
      bank_head_ptr  <= '0;
      bank_tail_ptr  <= '0;
    end else begin
      head          <= head_n;
      tail          <= tail_n;
      occ           <= occ_n;
      free_slots    <= OCC_W'(ROB_DEPTH) - occ_n;
      bank_head_ptr <= bank_ptrs(head_n);
      bank_tail_ptr <= bank_ptrs(tail_n);
      case (state)
        S_RUN: begin
          if (misp_retire) begin
            state          <= S_FLUSH;
            flush          <= 1'b1;
            dispatch_ready <= 1'b0;
          end
        end
        S_FLUSH: begin
          state <= S_RECOVER;
          flush <= 1'b0;
        end
        S_RECOVER: begin
          if (flush_ack) begin
            state          <= S_RUN;
            dispatch_ready <= 1'b1;
          end
        end
        default: begin
          state          <= S_RUN;
          flush          <= 1'b0;
          dispatch_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed vector bench for rob_retire_ctrl: table of per-cycle vectors plus
// hand-written sequences for full/wrap, simultaneous events and reset during flush.
module tb_rob_retire_ctrl;

  logic            clk;
  logic            rst_n;
  logic [2:0]      bank_head_complete;
  logic [2:0]      bank_head_misp;
  logic            retire_stall;
  logic [1:0]      dispatch_num;
  logic            flush_ack;
  logic [2:0]      bank_head_accept;
  logic [2:0][4:0] bank_head_ptr;
  logic [2:0][4:0] bank_tail_ptr;
  logic [1:0]      retire_count;
  logic [6:0]      free_slots;
  logic            flush;
  logic            dispatch_ready;

  int checks;
  int errors;

  rob_retire_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bank_head_complete (bank_head_complete),
    .bank_head_misp     (bank_head_misp),
    .retire_stall       (retire_stall),
    .dispatch_num       (dispatch_num),
    .flush_ack          (flush_ack),
    .bank_head_accept   (bank_head_accept),
    .bank_head_ptr      (bank_head_ptr),
    .bank_tail_ptr      (bank_tail_ptr),
    .retire_count       (retire_count),
    .free_slots         (free_slots),
    .flush              (flush),
    .dispatch_ready     (dispatch_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  cmp;
    logic [2:0]  misp;
    logic        stall;
    logic [1:0]  dnum;
    logic        fack;
    logic [2:0]  acc;
    logic [1:0]  cnt;
    logic [6:0]  free;
    logic        fl;
    logic        rdy;
    logic [14:0] hp;
    logic [14:0] tp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  // Pack per-bank pointers as {bank2, bank1, bank0}
  function automatic logic [14:0] pp(input int p2, input int p1, input int p0);
    return {5'(p2), 5'(p1), 5'(p0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and let combinational outputs settle
  task automatic drive(input logic r, input logic [2:0] c, input logic [2:0] m,
                       input logic st, input logic [1:0] d, input logic fa);
    @(negedge clk);
    rst_n              = r;
    bank_head_complete = c;
    bank_head_misp     = m;
    retire_stall       = st;
    dispatch_num       = d;
    flush_ack          = fa;
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bank_head_complete = '0;
    bank_head_misp = '0;
    retire_stall = 1'b0;
    dispatch_num = '0;
    flush_ack = 1'b0;

    //           rst  cmp     misp    stl  dnum  fack  acc     cnt  free   fl    rdy   hp            tp
    vecs[0]  = '{1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 2'd0, 7'd96, 1'b0, 1'b1, pp(0,0,0), pp(0,0,0)};
    vecs[1]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd3, 1'b0, 3'b000, 2'd0, 7'd96, 1'b0, 1'b1, pp(0,0,0), pp(0,0,0)};
    vecs[2]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd3, 1'b0, 3'b000, 2'd0, 7'd93, 1'b0, 1'b1, pp(0,0,0), pp(1,1,1)};
    vecs[3]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd3, 1'b0, 3'b000, 2'd0, 7'd90, 1'b0, 1'b1, pp(0,0,0), pp(2,2,2)};
    vecs[4]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd3, 1'b0, 3'b000, 2'd0, 7'd87, 1'b0, 1'b1, pp(0,0,0), pp(3,3,3)};
    vecs[5]  = '{1'b1, 3'b011, 3'b000, 1'b0, 2'd0, 1'b0, 3'b011, 2'd2, 7'd84, 1'b0, 1'b1, pp(0,0,0), pp(4,4,4)};
    vecs[6]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 3'b000, 2'd0, 7'd86, 1'b0, 1'b1, pp(0,1,1), pp(4,4,4)};
    vecs[7]  = '{1'b1, 3'b100, 3'b000, 1'b0, 2'd0, 1'b0, 3'b100, 2'd1, 7'd86, 1'b0, 1'b1, pp(0,1,1), pp(4,4,4)};
    vecs[8]  = '{1'b1, 3'b110, 3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 2'd0, 7'd87, 1'b0, 1'b1, pp(1,1,1), pp(4,4,4)};
    vecs[9]  = '{1'b1, 3'b001, 3'b000, 1'b1, 2'd0, 1'b0, 3'b000, 2'd0, 7'd87, 1'b0, 1'b1, pp(1,1,1), pp(4,4,4)};
    vecs[10] = '{1'b1, 3'b111, 3'b010, 1'b0, 2'd3, 1'b0, 3'b011, 2'd2, 7'd87, 1'b0, 1'b1, pp(1,1,1), pp(4,4,4)};
    vecs[11] = '{1'b1, 3'b111, 3'b000, 1'b0, 2'd3, 1'b1, 3'b000, 2'd0, 7'd86, 1'b1, 1'b0, pp(1,2,2), pp(5,5,5)};
    vecs[12] = '{1'b1, 3'b111, 3'b000, 1'b0, 2'd3, 1'b0, 3'b000, 2'd0, 7'd96, 1'b0, 1'b0, pp(1,2,2), pp(1,2,2)};
    vecs[13] = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd3, 1'b1, 3'b000, 2'd0, 7'd96, 1'b0, 1'b0, pp(1,2,2), pp(1,2,2)};
    vecs[14] = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd3, 1'b0, 3'b000, 2'd0, 7'd96, 1'b0, 1'b1, pp(1,2,2), pp(1,2,2)};
    vecs[15] = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 2'd0, 7'd93, 1'b0, 1'b1, pp(1,2,2), pp(2,3,3)};

    // Two reset cycles
    drive(1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].cmp, vecs[i].misp, vecs[i].stall, vecs[i].dnum, vecs[i].fack);
      chk($sformatf("v%0d_accept", i), 32'(bank_head_accept), 32'(vecs[i].acc));
      chk($sformatf("v%0d_count", i),  32'(retire_count),     32'(vecs[i].cnt));
      chk($sformatf("v%0d_free", i),   32'(free_slots),       32'(vecs[i].free));
      chk($sformatf("v%0d_flush", i),  32'(flush),            32'(vecs[i].fl));
      chk($sformatf("v%0d_ready", i),  32'(dispatch_ready),   32'(vecs[i].rdy));
      chk($sformatf("v%0d_head", i),   32'(bank_head_ptr),    32'(vecs[i].hp));
      chk($sformatf("v%0d_tail", i),   32'(bank_tail_ptr),    32'(vecs[i].tp));
    end

    // Reset back to empty
    drive(1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
    idle();
    chk("rst_free", 32'(free_slots), 32'd96);
    chk("rst_tail", 32'(bank_tail_ptr), 32'(pp(0,0,0)));

    // Fill to 96 entries; tail wraps to row 0 bank 0
    for (int i = 0; i < 32; i++) drive(1'b1, 3'b000, 3'b000, 1'b0, 2'd3, 1'b0);
    drive(1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0);
    chk("full_free", 32'(free_slots), 32'd0);
    chk("full_tail", 32'(bank_tail_ptr), 32'(pp(0,0,0)));
    drive(1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 1'b0);
    chk("full_ovf_free", 32'(free_slots), 32'd0);
    chk("full_ovf_tail", 32'(bank_tail_ptr), 32'(pp(0,0,0)));
    chk("full_ret_acc", 32'(bank_head_accept), 32'(3'b111));
    chk("full_ret_cnt", 32'(retire_count), 32'd3);
    drive(1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0);
    chk("after_ret_free", 32'(free_slots), 32'd3);
    chk("after_ret_head", 32'(bank_head_ptr), 32'(pp(1,1,1)));

    // occ 94: dispatch 2 with retire 3
    drive(1'b1, 3'b111, 3'b000, 1'b0, 2'd2, 1'b0);
    chk("sim94_free", 32'(free_slots), 32'd2);
    chk("sim94_acc", 32'(bank_head_accept), 32'(3'b111));
    chk("sim94_tail", 32'(bank_tail_ptr), 32'(pp(0,0,1)));
    drive(1'b1, 3'b000, 3'b000, 1'b0, 2'd2, 1'b0);
    chk("sim94_result", 32'(free_slots), 32'd3);
    chk("sim94_tail2", 32'(bank_tail_ptr), 32'(pp(1,1,1)));

    // occ 95: dispatch 3 is over-size, retire 3 still applies
    drive(1'b1, 3'b111, 3'b000, 1'b0, 2'd3, 1'b0);
    chk("sim95_free", 32'(free_slots), 32'd1);
    chk("sim95_cnt", 32'(retire_count), 32'd3);
    chk("sim95_tail", 32'(bank_tail_ptr), 32'(pp(1,2,2)));
    idle();
    chk("sim95_result", 32'(free_slots), 32'd4);
    chk("sim95_tail2", 32'(bank_tail_ptr), 32'(pp(1,2,2)));
    chk("sim95_head", 32'(bank_head_ptr), 32'(pp(3,3,3)));

    // Walk head to row 31 bank 2, then retire one to wrap the full circle
    for (int i = 0; i < 28; i++) drive(1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 3'b011, 3'b000, 1'b0, 2'd0, 1'b0);
    chk("wrap_head_r31b0", 32'(bank_head_ptr), 32'(pp(31,31,31)));
    chk("wrap_acc2", 32'(bank_head_accept), 32'(3'b011));
    drive(1'b1, 3'b100, 3'b000, 1'b0, 2'd0, 1'b0);
    chk("wrap_head_r31b2", 32'(bank_head_ptr), 32'(pp(31,0,0)));
    chk("wrap_acc1", 32'(bank_head_accept), 32'(3'b100));
    chk("wrap_cnt1", 32'(retire_count), 32'd1);
    idle();
    chk("wrap_head_r0b0", 32'(bank_head_ptr), 32'(pp(0,0,0)));
    chk("wrap_free", 32'(free_slots), 32'd91);

    // Mispredict on slot 0, then reset during the flush cycle
    drive(1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 1'b0);
    chk("misp0_acc", 32'(bank_head_accept), 32'(3'b001));
    drive(1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
    chk("misp0_flush", 32'(flush), 32'd1);
    drive(1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
    chk("rstfl_flush", 32'(flush), 32'd0);
    chk("rstfl_ready", 32'(dispatch_ready), 32'd1);
    chk("rstfl_free", 32'(free_slots), 32'd96);
    chk("rstfl_head", 32'(bank_head_ptr), 32'(pp(0,0,0)));
    idle();
    chk("rstfl_flush2", 32'(flush), 32'd0);
    chk("rstfl_ready2", 32'(dispatch_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_retire_ctrl.md
# rob_retire_ctrl

Retirement and pointer controller for the 3-bank, bank-interleaved reorder buffer. It owns the global head/tail state and derives the per-bank head_ptr/tail_ptr that each ROB bank consumes. Each cycle it samples the banks' head_complete/misprediction flags, retires up to three instructions in program order, and returns head_complete_accept. After a mispredicted branch retires, it sequences a pipeline flush.

## Interface
- MACHINE_WIDTH, 3: number of banks, which is also the maximum retire and dispatch width per cycle. Fixed at 3.
- ROB_DEPTH_BANK, 32: entries per bank. ROB_WIDTH_BANK = log2(ROB_DEPTH_BANK) = 5. Total ROB depth is 96.
- clk, input, 1: the single clock.
- rst_n, input, 1: reset. Synchronous, active-low.
- bank_head_complete, input, [2:0]: head_complete from bank b, on bit b.
- bank_head_misp, input, [2:0]: branch_misp of bank b's head entry.
- retire_stall, input, 1: when 1, no retirement this cycle.
- dispatch_num, input, 2: number of entries allocated this cycle, 0..3.
- flush_ack, input, 1: frontend has finished recovery.
- bank_head_accept, output, [2:0]: head_complete_accept to bank b.
- bank_head_ptr, output, 3×5: head_ptr for bank b.
- bank_tail_ptr, output, 3×5: tail_ptr for bank b.
- retire_count, output, 2: number of instructions retired this cycle.
- free_slots, output, 7: 96 − occupancy.
- flush, output, 1: one-cycle flush pulse to the banks, rename and the frontend.
- dispatch_ready, output, 1: controller accepts dispatch this cycle.

## Operation
- **State registers**
  - head_bank and tail_bank: 2 bits each, range 0..2.
  - head_row and tail_row: 5 bits each.
  - occ: 7 bits, range 0..96.
  - FSM: RUN, FLUSH, RECOVER.
- **Interleaving**
  - Entry k lives in bank k mod 3, row floor(k/3) mod 32.
  - bank_head_ptr[b] = head_row + (b < head_bank ? 1 : 0), mod 32.
  - bank_tail_ptr[b] = tail_row + (b < tail_bank ? 1 : 0), mod 32.
- **Retire slots**
  - Slot j (j = 0..2) maps to bank s_j = (head_bank + j) mod 3.
  - Slot j retires iff all of the following hold:
    - state is RUN;
    - retire_stall = 0;
    - occ > j;
    - bank_head_complete[s_j] = 1;
    - every slot i < j retires;
    - bank_head_misp[s_i] = 0 for every i < j.
  - A mispredicted branch retires itself. All younger slots are blocked.
- **Accept and count**
  - bank_head_accept[s_j] = 1 for each retiring slot j.
  - retire_count = number of retiring slots, R.
- **Head advance**
  - Head advances by R: head_bank += R.
  - On bank wrap past 2, head_bank is taken mod 3 and head_row increments.
  - head_row wraps 31 → 0.
- **Dispatch**
  - Dispatch is accepted iff all of: state is RUN, dispatch_num ≤ free_slots (value at start of cycle), and dispatch_num ≠ 0.
  - An over-size request is ignored entirely: no partial allocation, no pointer change.
  - Tail advances by dispatch_num using the same wrap rules as the head.
- **Occupancy and ready**
  - occ_next = occ + accepted_dispatch − R.
  - A retire and a dispatch in the same cycle are both applied.
  - dispatch_ready = (state == RUN).
- **FSM**
  - RUN → FLUSH when a retiring slot has bank_head_misp = 1.
  - FLUSH lasts exactly one cycle:
    - flush = 1, accepts = 0, dispatch ignored;
    - tail_bank/tail_row ← head_bank/head_row (the already-advanced values), occ ← 0.
  - FLUSH → RECOVER unconditionally.
  - RECOVER → RUN on flush_ack = 1, sampled at the clock edge. Retire and dispatch resume in the first RUN cycle.
  - flush_ack is ignored in the RUN and FLUSH states.
- **Reset**
  - Applied when rst_n = 0 at a rising edge.
  - All pointers 0, occ 0, state RUN.
  - Outputs: accept 0, retire_count 0, flush 0, free_slots 96, dispatch_ready 1, all bank pointers 0.
  - Reset asserted mid-flush or mid-RECOVER returns the controller to RUN with no flush pulse.

## Timing
- bank_head_accept and retire_count are combinational from the bank inputs and the current state (zero-cycle). The banks clear the entry at the same edge.
- Pointer, occ and free_slots updates are visible the cycle after the retire/dispatch.
- flush rises the cycle after the mispredicted branch's accept and lasts exactly one cycle.
- Minimum misprediction bubble is 2 cycles: FLUSH, then RECOVER with flush_ack already high.
- Corner cases:
  - Full: occ = 96 ⇒ free_slots = 0 and every nonzero dispatch is ignored.
  - Empty: occ = 0 ⇒ no accept, even if stale complete flags are high.
  - Full-circle wrap: at head_row = 31, head_bank = 2, retiring 1 gives head_row 0, head_bank 0.

## Test plan
- **Reset and idle:** hold rst_n = 0 for 2 cycles, then release → all outputs at reset values, free_slots = 96, flush = 0.
- **In-order retire:**
  - dispatch_num = 3 for 4 cycles → occ = 12, tail_row = 4, tail_bank = 0.
  - complete = 3'b011 → accept = 3'b011, retire_count = 2; next cycle head_bank = 2, bank_head_ptr = {1,1,0}.
- **Ordering block:** head_bank = 0, complete = 3'b110 → accept = 0, retire_count = 0, pointers unchanged.
- **Full/wrap:**
  - Dispatch 3 for 32 cycles → free_slots = 0, tail wraps back to row 0, bank 0.
  - dispatch_num = 1 → ignored.
  - Retire 3 → free_slots = 3 next cycle.
- **Misprediction:** head_bank = 0, complete = 3'b111, misp = 3'b010 →
  - accept = 3'b011, retire_count = 2;
  - next cycle flush = 1, occ = 0, tail = head = (row 0, bank 2);
  - dispatch ignored until 1 cycle after flush_ack.
- **Simultaneous events:**
  - occ = 94, dispatch 2 with retire 3 → occ = 93.
  - occ = 95, dispatch 3 with retire 3 → dispatch ignored (free = 1 at cycle start), occ = 92.
